// File: rtl/dda_param_loader.sv
`timescale 1ns/1ps
// dda_param_loader: byte-stream frame loader for the Lorenz dda parameters.
// Frame: header 0xA5, then seven N-bit words (icx, icy, icz, sigma, beta, rho, dt),
// each MSB byte first. Optional trailing XOR checksum byte when DDA_LOADER_CHECKSUM_EN
// is defined; the default build has no checksum and err is tied low.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_data/in_valid/ready byte input handshake (transfer when valid & ready)
//   icx..dt                committed words, updated atomically at commit
//   run                    dda enable, high from a commit until the next header/error
//   start                  one-cycle pulse with each commit
//   err                    one-cycle pulse on checksum rejection
module dda_param_loader #(
    parameter int unsigned N  = 16,
    parameter int unsigned ES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] icx,
    output logic [N-1:0] icy,
    output logic [N-1:0] icz,
    output logic [N-1:0] sigma,
    output logic [N-1:0] beta,
    output logic [N-1:0] rho,
    output logic [N-1:0] dt,
    output logic         run,
    output logic         start,
    output logic         err
);

    localparam int unsigned B     = N / 8;
    localparam int unsigned WORDS = 7;
    localparam int unsigned PAY   = WORDS * B;
    localparam int unsigned SW    = WORDS * N;
    localparam int unsigned CW    = $clog2(PAY + 1);
    localparam logic [7:0]  HDR   = 8'hA5;

    // ES has no datapath role; it only participates in the configuration sanity check.
    if ((N % 8) != 0 || N == 0 || ES >= N) begin : g_bad_cfg
        $error("dda_param_loader: N must be a non-zero multiple of 8 and ES < N");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
`ifdef DDA_LOADER_CHECKSUM_EN
        S_CHECK  = 2'd2,
`endif
        S_COMMIT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shadow_q, shadow_d;
    logic [N-1:0]    word_q [WORDS];
    logic [N-1:0]    word_d [WORDS];
    logic            run_q, run_d;
    logic            start_q, start_d;

    logic            accept;
    logic            hdr_acc;
    logic            pay_acc;
    logic            commit;
    logic            csum_bad;
`ifdef DDA_LOADER_CHECKSUM_EN
    logic            csum_ok;
    logic [7:0]      csum_q, csum_d;
    logic            err_q, err_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hdr_acc) state_d = S_LOAD;
            S_LOAD: begin
                if (pay_acc && cnt_q == CW'(PAY - 1)) begin
`ifdef DDA_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_COMMIT;
`endif
                end
            end
`ifdef DDA_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (csum_ok)  state_d = S_COMMIT;
                if (csum_bad) state_d = S_IDLE;
            end
`endif
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State decode: handshake and datapath strobes
    always_comb begin
        in_ready = ~rst & (state_q != S_COMMIT);
        accept   = in_valid & in_ready;
        hdr_acc  = accept & (state_q == S_IDLE) & (in_data == HDR);
        pay_acc  = accept & (state_q == S_LOAD);
        commit   = (state_q == S_COMMIT);
`ifdef DDA_LOADER_CHECKSUM_EN
        csum_ok  = accept & (state_q == S_CHECK) & (in_data == csum_q);
        csum_bad = accept & (state_q == S_CHECK) & (in_data != csum_q);
`else
        csum_bad = 1'b0;
`endif
    end

    // Datapath next values: shadow shift-in, counter, commit of the seven words
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        run_d    = run_q;
        start_d  = 1'b0;
        for (int k = 0; k < int'(WORDS); k++) word_d[k] = word_q[k];
`ifdef DDA_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        err_d    = csum_bad;
`endif
        if (hdr_acc) begin
            cnt_d = '0;
            run_d = 1'b0;
`ifdef DDA_LOADER_CHECKSUM_EN
            csum_d = 8'h00;
`endif
        end
        if (pay_acc) begin
            // Shifting in MSB-first leaves icx in the top N bits after the last byte.
            shadow_d = {shadow_q[SW-9:0], in_data};
            cnt_d    = cnt_q + CW'(1);
`ifdef DDA_LOADER_CHECKSUM_EN
            csum_d   = csum_q ^ in_data;
`endif
        end
        if (commit) begin
            for (int k = 0; k < int'(WORDS); k++) begin
                word_d[k] = shadow_q[(int'(WORDS) - k) * int'(N) - 1 -: N];
            end
            run_d   = 1'b1;
            start_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            for (int k = 0; k < int'(WORDS); k++) word_q[k] <= '0;
            run_q    <= 1'b0;
            start_q  <= 1'b0;
`ifdef DDA_LOADER_CHECKSUM_EN
            csum_q   <= 8'h00;
            err_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            for (int k = 0; k < int'(WORDS); k++) word_q[k] <= word_d[k];
            run_q    <= run_d;
            start_q  <= start_d;
`ifdef DDA_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
            err_q    <= err_d;
`endif
        end
    end

    assign icx   = word_q[0];
    assign icy   = word_q[1];
    assign icz   = word_q[2];
    assign sigma = word_q[3];
    assign beta  = word_q[4];
    assign rho   = word_q[5];
    assign dt    = word_q[6];
    assign run   = run_q;
    assign start = start_q;
`ifdef DDA_LOADER_CHECKSUM_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_dda_param_loader.sv
`timescale 1ns/1ps
module tb_dda_param_loader;

    localparam int unsigned N  = 16;
    localparam int unsigned B  = N / 8;
    localparam int unsigned SW = 7 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] icx, icy, icz, sigma, beta, rho, dt;
    logic         run, start, err;

    dda_param_loader #(.N(N), .ES(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .icx      (icx),
        .icy      (icy),
        .icz      (icz),
        .sigma    (sigma),
        .beta     (beta),
        .rho      (rho),
        .dt       (dt),
        .run      (run),
        .start    (start),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [SW-1:0] exp_q[$];
    int err_exp  = 0;
    int commits  = 0;
    int lo_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every start pulse pops one expected commit.
    logic [SW-1:0] prev_words;
    logic          prev_ready = 1'b1;
    always @(negedge clk) begin
        logic [SW-1:0] cur;
        logic [SW-1:0] e;
        cur = {icx, icy, icz, sigma, beta, rho, dt};
        if (rst) begin
            prev_words = cur;
            prev_ready = 1'b1;
        end else begin
            if (!in_ready) lo_cnt++;
            if (start) begin
                chk("start_err_excl", {31'd0, err}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("icx",   {16'd0, icx},   {16'd0, e[7*N-1 -: N]});
                    chk("icy",   {16'd0, icy},   {16'd0, e[6*N-1 -: N]});
                    chk("icz",   {16'd0, icz},   {16'd0, e[5*N-1 -: N]});
                    chk("sigma", {16'd0, sigma}, {16'd0, e[4*N-1 -: N]});
                    chk("beta",  {16'd0, beta},  {16'd0, e[3*N-1 -: N]});
                    chk("rho",   {16'd0, rho},   {16'd0, e[2*N-1 -: N]});
                    chk("dt",    {16'd0, dt},    {16'd0, e[N-1 -: N]});
                    chk("run_at_commit", {31'd0, run}, 32'd1);
                    chk("ready_low_in_commit", {31'd0, prev_ready}, 32'd0);
                    chk("ready_after_commit", {31'd0, in_ready}, 32'd1);
                end
            end else if (cur !== prev_words) begin
                chk("words_changed_without_commit", 32'd1, 32'd0);
            end
            if (err) begin
                if (err_exp == 0) chk("unexpected_err", 32'd1, 32'd0);
                else err_exp--;
            end
            prev_words = cur;
            prev_ready = in_ready;
        end
    end

    // One byte: drive at negedge, wait (bounded) for ready, transfer at posedge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [SW-1:0] w, input bit gap, input logic [7:0] flip);
        logic [7:0] cs;
        logic [7:0] b;
        bit         expect_commit;
        cs = 8'h00;
`ifdef DDA_LOADER_CHECKSUM_EN
        expect_commit = (flip == 8'h00);
`else
        expect_commit = 1'b1;
`endif
        if (expect_commit) begin
            exp_q.push_back(w);
            commits++;
        end
        send_byte(8'hA5, gap);
        chk("run_drop_on_header", {31'd0, run}, 32'd0);
        for (int i = 0; i < int'(7 * B); i++) begin
            b  = w[SW - 1 - 8 * i -: 8];
            cs = cs ^ b;
            send_byte(b, gap);
        end
`ifdef DDA_LOADER_CHECKSUM_EN
        if (flip != 8'h00) err_exp++;
        send_byte(cs ^ flip, gap);
`endif
        if (expect_commit) begin
            chk("start_not_early", {31'd0, start}, 32'd0);
            chk("ready_in_commit", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("start_latency", {31'd0, start}, 32'd1);
            @(posedge clk);
            #1;
            chk("start_width", {31'd0, start}, 32'd0);
        end else begin
            @(posedge clk);
            @(posedge clk);
            #1;
            chk("no_start_on_bad", {31'd0, start}, 32'd0);
            chk("run_low_after_err", {31'd0, run}, 32'd0);
            chk("err_width", {31'd0, err}, 32'd0);
        end
    endtask

    logic [SW-1:0] fa, fb, f4, fbad;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        fa = {16'h0001, 16'h0002, 16'h0003, 16'h000A, 16'h001C, 16'h0008, 16'h0020};
        fb = {16'hA5A5, 16'h1234, 16'h00A5, 16'hFFFF, 16'h8000, 16'h0100, 16'h7FFF};
        f4 = {7{16'h4000}};
        fbad = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_run",   {31'd0, run},      32'd0);
        chk("rst_start", {31'd0, start},    32'd0);
        chk("rst_err",   {31'd0, err},      32'd0);
        chk("rst_icx",   {16'd0, icx},      32'd0);
        chk("rst_dt",    {16'd0, dt},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Basic frame
        send_frame(fa, 1'b0, 8'h00);
        // Preamble bytes ignored
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_frame(fa, 1'b0, 8'h00);
        // in_valid toggling every cycle
        send_frame(fa, 1'b1, 8'h00);
        // 0xA5 bytes inside the payload are data
        send_frame(fb, 1'b0, 8'h00);

        // Reset mid-frame, with a header byte offered during reset
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'h77, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_data = 8'hA5;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_icx",   {16'd0, icx},      32'd0);
        chk("midrst_run",   {31'd0, run},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_midrst", {31'd0, in_ready}, 32'd1);
        send_frame(f4, 1'b0, 8'h00);
        chk("run_after_f4", {31'd0, run}, 32'd1);

`ifdef DDA_LOADER_CHECKSUM_EN
        send_frame(fa, 1'b0, 8'h00);
        send_frame(fbad, 1'b0, 8'h01);
        chk("hold_icx_after_err", {16'd0, icx}, 32'h0001);
        chk("hold_dt_after_err",  {16'd0, dt},  32'h0020);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("err_expect_done", err_exp, 32'd0);
        chk("ready_low_cycles", lo_cnt, commits);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
